// File: rtl/nn_pkg.sv
// Shared constants and types for the neural-net classification datapath.
package nn_pkg;
  localparam int DATA_W = 8;
  localparam int ELEMS  = 4;
  localparam int ACC_W  = 2*DATA_W + $clog2(ELEMS);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} dp_state_t;
  typedef logic signed [DATA_W-1:0] elem_t;
endpackage

// File: rtl/nn_mac.sv
// Signed multiply-accumulate lane; o_sum is the running total including the current product.
module nn_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_acc_en,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [ACC_W-1:0]  o_sum
);
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_prod = i_a * i_b;
  assign o_sum  = r_acc + {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_acc_en) begin
      r_acc <= o_sum;
    end
  end
endmodule

// File: rtl/nn_classify_dp.sv
// Two-kernel dot-product classifier: FSM walks ELEMS weights, compares the sums and holds the
// winner on a valid/ready output. Handshake: a result transfers in any cycle with res_valid && res_ready.
module nn_classify_dp #(
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter int ELEMS  = nn_pkg::ELEMS,
  parameter int ACC_W  = 2*DATA_W + $clog2(ELEMS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     classify,
  input  logic                     en,
  input  logic [DATA_W*ELEMS-1:0]  kdata0,
  input  logic [DATA_W*ELEMS-1:0]  kdata1,
  input  logic [DATA_W-1:0]        wdata,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     res_class,
  output logic signed [ACC_W-1:0]  score0,
  output logic signed [ACC_W-1:0]  score1,
  output logic                     ovf,
  output nn_pkg::dp_state_t        dbg_state
);
  import nn_pkg::*;

  localparam int CNT_W = $clog2(ELEMS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ELEMS-1);

  dp_state_t              r_state, w_next_state;
  logic [CNT_W-1:0]       r_cnt, w_next_cnt;
  logic                   w_clr, w_acc_en, w_done;
  logic [DATA_W-1:0]      w_k0, w_k1;
  logic signed [ACC_W-1:0] w_sum0, w_sum1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Abort on classify low beats everything; en on the last element is the back-to-back case.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_clr        = 1'b0;
    w_acc_en     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_next_state = ACC;
          w_next_cnt   = '0;
          w_clr        = 1'b1;
        end
      end
      ACC: begin
        if (!classify) begin
          w_next_state = IDLE;
          w_next_cnt   = '0;
        end else if (r_cnt == LAST) begin
          w_done     = 1'b1;
          w_next_cnt = '0;
          if (en) w_clr = 1'b1;
          else    w_next_state = IDLE;
        end else if (en) begin
          w_clr      = 1'b1;
          w_next_cnt = '0;
        end else begin
          w_acc_en   = 1'b1;
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign dbg_state = r_state;
  assign w_k0 = kdata0[r_cnt*DATA_W +: DATA_W];
  assign w_k1 = kdata1[r_cnt*DATA_W +: DATA_W];

  nn_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac0 (
    .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_acc_en(w_acc_en),
    .i_a(w_k0), .i_b(wdata), .o_sum(w_sum0)
  );

  nn_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac1 (
    .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_acc_en(w_acc_en),
    .i_a(w_k1), .i_b(wdata), .o_sum(w_sum1)
  );

  // A completion that finds the previous result unaccepted is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_class <= 1'b0;
      score0    <= '0;
      score1    <= '0;
      ovf       <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (w_done) begin
        if (res_valid && !res_ready) begin
          ovf <= 1'b1;
        end else begin
          res_valid <= 1'b1;
          res_class <= (w_sum0 < w_sum1);
          score0    <= w_sum0;
          score1    <= w_sum1;
        end
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_nn_classify_dp.sv
// Directed and randomized bench for nn_classify_dp against a plain dot-product reference model.
module tb_nn_classify_dp;
  import nn_pkg::*;

  localparam int DW = DATA_W;
  localparam int EL = ELEMS;
  localparam int AW = ACC_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic classify = 1'b0;
  logic en = 1'b0;
  logic res_ready = 1'b0;
  logic [DW*EL-1:0] kdata0 = '0;
  logic [DW*EL-1:0] kdata1 = '0;
  logic [DW-1:0] wdata = '0;
  logic res_valid, res_class, ovf;
  logic signed [AW-1:0] score0, score1;
  dp_state_t dbg_state;

  int checks = 0;
  int failures = 0;

  logic signed [DW-1:0] k0a[EL];
  logic signed [DW-1:0] k1a[EL];
  logic signed [DW-1:0] wb[16];
  logic [2*AW:0] exp_q[$];

  nn_classify_dp dut (
    .clk(clk), .rst_n(rst_n), .classify(classify), .en(en),
    .kdata0(kdata0), .kdata1(kdata1), .wdata(wdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .score0(score0), .score1(score1), .ovf(ovf), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int dot0(input int base);
    int s = 0;
    for (int i = 0; i < EL; i++) s += int'(k0a[i]) * int'(wb[base+i]);
    return s;
  endfunction

  function automatic int dot1(input int base);
    int s = 0;
    for (int i = 0; i < EL; i++) s += int'(k1a[i]) * int'(wb[base+i]);
    return s;
  endfunction

  task automatic apply_kernels();
    for (int i = 0; i < EL; i++) begin
      kdata0[i*DW +: DW] = k0a[i];
      kdata1[i*DW +: DW] = k1a[i];
    end
  endtask

  task automatic rand_kernels();
    for (int i = 0; i < EL; i++) begin
      k0a[i] = 8'($urandom_range(0, 255));
      k1a[i] = 8'($urandom_range(0, 255));
    end
    apply_kernels();
  endtask

  task automatic rand_weights();
    for (int i = 0; i < 16; i++) wb[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic push_exp(input int base);
    int s0, s1;
    logic cls;
    s0 = dot0(base);
    s1 = dot1(base);
    cls = (s0 < s1) ? 1'b1 : 1'b0;
    exp_q.push_back({cls, AW'(s0), AW'(s1)});
  endtask

  task automatic check_result(input string tag);
    logic [2*AW:0] e;
    logic signed [AW-1:0] e0, e1;
    chk({tag, "_qnonempty"}, (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      e0 = e[2*AW-1:AW];
      e1 = e[AW-1:0];
      chk({tag, "_valid"}, res_valid, 1);
      chk({tag, "_score0"}, score0, e0);
      chk({tag, "_score1"}, score1, e1);
      chk({tag, "_class"}, res_class, e[2*AW]);
      chk({tag, "_ovf"}, ovf, 0);
    end
  endtask

  // One isolated transaction using wb[0..EL-1]; result expected exactly 5 steps after en.
  task automatic single(input string tag);
    classify = 1'b1;
    en = 1'b1;
    res_ready = 1'b1;
    push_exp(0);
    for (int i = 0; i < EL; i++) begin
      tick();
      chk({tag, "_early_valid"}, res_valid, 0);
      en = 1'b0;
      wdata = wb[i];
    end
    tick();
    check_result(tag);
    classify = 1'b0;
    wdata = '0;
    tick();
    chk({tag, "_valid_one_cycle"}, res_valid, 0);
  endtask

  initial begin
    logic signed [AW-1:0] a0, a1;

    // Reset state
    #12;
    chk("rst_valid", res_valid, 0);
    chk("rst_class", res_class, 0);
    chk("rst_score0", score0, 0);
    chk("rst_score1", score1, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_state", dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic compare
    k0a = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    k1a = '{8'sd4, 8'sd3, 8'sd2, 8'sd1};
    apply_kernels();
    wb[0] = 8'sd1; wb[1] = 8'sd0; wb[2] = 8'sd0; wb[3] = 8'sd0;
    single("basic");

    // Tie goes to class 0
    for (int i = 0; i < EL; i++) wb[i] = 8'sd1;
    single("tie");

    // Signed extremes
    for (int i = 0; i < EL; i++) begin
      k0a[i] = 8'sh80; k1a[i] = 8'sh80; wb[i] = 8'sh80;
    end
    apply_kernels();
    single("neg_max");
    for (int i = 0; i < EL; i++) k0a[i] = 8'sd127;
    apply_kernels();
    single("pos_neg");

    // Random single transactions
    for (int n = 0; n < 12; n++) begin
      rand_kernels();
      rand_weights();
      single("rand");
    end

    // Back-to-back: en every EL cycles with classify held
    rand_kernels();
    rand_weights();
    push_exp(0);
    push_exp(4);
    push_exp(8);
    res_ready = 1'b1;
    for (int s = 0; s <= 13; s++) begin
      if (s > 0) begin
        tick();
        if (s == 5 || s == 9 || s == 13) check_result("b2b");
        else chk("b2b_valid_low", res_valid, 0);
        chk("b2b_ovf", ovf, 0);
      end
      classify = (s <= 12);
      en = ((s % 4) == 0) && (s <= 8);
      wdata = (s >= 1 && s <= 12) ? wb[s-1] : '0;
    end
    classify = 1'b0;
    en = 1'b0;

    // Abort: classify dropped after two samples
    rand_kernels();
    rand_weights();
    for (int s = 0; s <= 9; s++) begin
      if (s > 0) begin
        tick();
        chk("abort_valid", res_valid, 0);
        chk("abort_ovf", ovf, 0);
      end
      classify = (s <= 2);
      en = (s == 0);
      wdata = (s >= 1 && s <= 3) ? wb[s-1] : '0;
    end
    chk("abort_state", dbg_state, IDLE);

    // Restart: en re-asserted after two samples; only the new four weights count
    rand_kernels();
    rand_weights();
    push_exp(4);
    for (int s = 0; s <= 8; s++) begin
      if (s > 0) begin
        tick();
        if (s == 8) check_result("restart");
        else chk("restart_valid_low", res_valid, 0);
        chk("restart_ovf", ovf, 0);
      end
      classify = (s <= 7);
      en = (s == 0 || s == 3);
      if (s == 1 || s == 2) wdata = wb[s-1];
      else if (s == 3) wdata = 8'h55;
      else if (s >= 4 && s <= 7) wdata = wb[s];
      else wdata = '0;
    end
    classify = 1'b0;
    en = 1'b0;
    tick();

    // Backpressure: second completion dropped, first retained, one ovf pulse
    rand_kernels();
    rand_weights();
    push_exp(0);
    a0 = AW'(dot0(0));
    a1 = AW'(dot1(0));
    res_ready = 1'b0;
    for (int s = 0; s <= 10; s++) begin
      if (s > 0) begin
        tick();
        if (s <= 4) chk("bp_valid_low", res_valid, 0);
        else if (s == 5) check_result("bp_first");
        else begin
          chk("bp_valid_held", res_valid, 1);
          chk("bp_score0_held", score0, a0);
          chk("bp_score1_held", score1, a1);
          chk("bp_ovf", ovf, (s == 9) ? 1 : 0);
        end
      end
      classify = (s <= 8);
      en = (s == 0 || s == 4);
      wdata = (s >= 1 && s <= 8) ? wb[s-1] : '0;
    end

    // Asynchronous reset with a pending result
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", res_valid, 0);
    chk("arst_class", res_class, 0);
    chk("arst_score0", score0, 0);
    chk("arst_score1", score1, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_state", dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    tick();
    chk("post_rst_valid", res_valid, 0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nn_classify_dp.md
# nn_classify_dp

Classification datapath directly downstream of the neural-net memory controller. It consumes the controller's `en` strobe together with the kernel-memory read words (kernel 0 at address 0, kernel 1 at address 1, held constant during classify) and the weight-memory read stream (one weight per cycle, four cycles). It computes two signed dot products, one per kernel, and compares them. The winning class and both scores are presented on a valid/ready output to the result consumer.

## Interface
- `DATA_W`, default 8: signed width of one kernel element and one weight.
- `ELEMS`, default 4: elements per dot product; must equal the controller's read-counter span.
- `ACC_W`, default `2*DATA_W+$clog2(ELEMS)` (18): accumulator and score width, signed.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock, shared with the controller.
- `rst_n`  in  1  asynchronous, active-low reset.
- `classify`  in  1  controller mode input, same signal the controller sees.
- `en`  in  1  controller strobe; weight 0 is valid on `wdata` in the next cycle.
- `kdata0`  in  `DATA_W*ELEMS`  kernel 0 word; element i is `[i*DATA_W +: DATA_W]`.
- `kdata1`  in  `DATA_W*ELEMS`  kernel 1 word, same packing.
- `wdata`  in  `DATA_W`  weight read data, one element per cycle.
- `res_valid`  out  1  result held until accepted.
- `res_ready`  in  1  consumer accepts when `res_valid && res_ready`.
- `res_class`  out  1  0 if score0 ≥ score1, otherwise 1.
- `score0`, `score1`  out  `ACC_W`  signed dot products.
- `ovf`  out  1  one-cycle pulse when a completed result is dropped.

## Operation
- FSM states:
  - IDLE → ACC when `en` is high. This clears both accumulators and `cnt` (2 bits).
  - ACC: each cycle, `acc0 += k0[cnt]*wdata` and `acc1 += k1[cnt]*wdata`, then `cnt++`.
  - ACC with `cnt==ELEMS-1`: the final sums are loaded into the result register.
    - If `en` is high in the same cycle, stay in ACC with `cnt=0` and accumulators cleared. This is the back-to-back case: the controller re-asserts `en` every ELEMS cycles while `classify` is held.
    - Otherwise go to IDLE.
  - ACC with `classify` low: abort to IDLE. No result, no `ovf`. Samples taken this cycle are discarded.
  - ACC with `en` high and `cnt≠ELEMS-1`: restart (`cnt=0`, accumulators cleared). The partial result is discarded and no `ovf` is raised.
- Arithmetic:
  - Multiplies are full-precision signed (2·DATA_W).
  - Sums are sign-extended to ACC_W and cannot overflow.
  - The compare is signed; a tie gives class 0.
- Output register:
  - On completion, load the scores and class, and set `res_valid`.
  - A handshake clears `res_valid`, unless a completion occurs in the same cycle. In that case the new result loads and `res_valid` stays 1.
  - A completion while `res_valid && !res_ready` keeps the old result and pulses `ovf`.
- The output register is independent of the FSM. Aborts and restarts never touch it.

## Timing
- Reset values:
  - State IDLE, `cnt=0`, accumulators 0.
  - `res_valid=0`, `res_class=0`, `score0=score1=0`, `ovf=0`.
- With `en` high at cycle t, weights are sampled at t+1..t+ELEMS.
  - The result is registered at the end of cycle t+ELEMS.
  - `res_valid` is first high in cycle t+ELEMS+1, i.e. 5 cycles after `en` with the defaults.
- Throughput: one result every ELEMS cycles when `classify` is held.
- Reset asserted mid-ACC or with a pending result: everything returns to reset values at once, and the pending result is lost.

## Structure
- Shared package `nn_pkg`:
  - `DATA_W`, `ELEMS`, `ACC_W` constants.
  - Typedef `dp_state_t` enum {IDLE, ACC}.
  - Typedef `elem_t`, signed [DATA_W-1:0].
- Sub-module `nn_mac`, instantiated twice (one lane per kernel).
  - Signed multiply-accumulate with `clr` and `acc_en` inputs and an ACC_W accumulator.
  - Clear has priority and loads zero.
- Top level contains the FSM, `cnt`, the element-select muxes, the comparator and the output register.

## Test plan
- Basic compare: k0={1,2,3,4}, k1={4,3,2,1}, w={1,0,0,0}, `res_ready=1` → score0=1, score1=4, class=1, `res_valid` high for exactly 1 cycle at t+5.
- Tie: same kernels, w={1,1,1,1} → score0=score1=10, class=0.
- Signed extremes: all elements and weights −128 → score0=score1=65536 with no overflow; then k0 all +127, w all −128 → score0=−65024, class=1.
- Back-to-back: `classify` held 12 cycles with `en` every 4 cycles and `res_ready=1` → 3 results on consecutive 4-cycle boundaries, no `ovf`.
- Abort and restart:
  - `classify` dropped after 2 samples → no `res_valid`, no `ovf`.
  - `en` re-asserted after 2 samples → a single result computed from the new 4 weights only.
- Backpressure and reset:
  - `res_ready=0` across two completions → first result retained and `ovf` pulses once.
  - `rst_n` low while the result is pending → all outputs return to 0 asynchronously.
